// File: rtl/vga_pkg.sv
// Shared VGA definitions: pixel-fetch FSM encoding and default 640x480@60 timing.
// The sync generator and the pixel fetch stage both take their timing from here.
package vga_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_FETCH = 1'b1
    } fetch_state_t;

    localparam int unsigned VGA_COLOR_W  = 8;
    localparam int unsigned VGA_CNT_W    = 10;
    localparam int unsigned VGA_H_ACTIVE = 640;
    localparam int unsigned VGA_H_TOTAL  = 800;
    localparam int unsigned VGA_V_ACTIVE = 480;
    localparam int unsigned VGA_V_TOTAL  = 525;
    localparam int unsigned VGA_READ_LAT = 2;

    localparam logic [23:0] VGA_UNDERFLOW_COLOR = 24'hFF00FF;

endpackage

// File: rtl/vga_lookahead.sv
// Combinational raster lookahead: the (column,line) position OFFSET pixels after
// (hcont,vcont), wrapping columns at H_TOTAL and lines at V_TOTAL.
// OFFSET must be smaller than H_TOTAL, so at most one column wrap can occur.
module vga_lookahead
    import vga_pkg::*;
#(
    parameter int unsigned CNT_W   = VGA_CNT_W,
    parameter int unsigned H_TOTAL = VGA_H_TOTAL,
    parameter int unsigned V_TOTAL = VGA_V_TOTAL,
    parameter int unsigned OFFSET  = VGA_READ_LAT + 1
) (
    input  logic [CNT_W-1:0] hcont_i,
    input  logic [CNT_W-1:0] vcont_i,
    output logic [CNT_W-1:0] ha_o,
    output logic [CNT_W-1:0] va_o
);

    localparam logic [CNT_W:0]   OFFSET_W = (CNT_W + 1)'(OFFSET);
    localparam logic [CNT_W:0]   HTOT_W   = (CNT_W + 1)'(H_TOTAL);
    localparam logic [CNT_W-1:0] VLAST    = CNT_W'(V_TOTAL - 1);

    logic [CNT_W:0] h_sum;
    logic [CNT_W:0] h_wrapped;

    // Advance the column by OFFSET one bit wider than the counter; carry into the line on wrap
    always_comb begin
        h_sum     = {1'b0, hcont_i} + OFFSET_W;
        h_wrapped = h_sum - HTOT_W;
        ha_o      = h_sum[CNT_W-1:0];
        va_o      = vcont_i;
        if (h_sum >= HTOT_W) begin
            ha_o = h_wrapped[CNT_W-1:0];
            va_o = (vcont_i == VLAST) ? '0 : vcont_i + CNT_W'(1);
        end
    end

endmodule

// File: rtl/vga_pixel_fetch.sv
// Pixel fetch / output stage between the frame-buffer read port and the VGA DAC.
// read_en is issued READ_LAT+1 pixels ahead so data lands when its pixel is on the
// counters; RGB is registered, giving a fixed one-clock display delay. Display is
// switched on and off only at the frame origin so frames are never cut short.
module vga_pixel_fetch
    import vga_pkg::*;
#(
    parameter int unsigned            COLOR_W         = VGA_COLOR_W,
    parameter int unsigned            CNT_W           = VGA_CNT_W,
    parameter int unsigned            H_ACTIVE        = VGA_H_ACTIVE,
    parameter int unsigned            H_TOTAL         = VGA_H_TOTAL,
    parameter int unsigned            V_ACTIVE        = VGA_V_ACTIVE,
    parameter int unsigned            V_TOTAL         = VGA_V_TOTAL,
    parameter int unsigned            READ_LAT        = VGA_READ_LAT,
    parameter logic [3*COLOR_W-1:0]   UNDERFLOW_COLOR = VGA_UNDERFLOW_COLOR
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   enable,
    input  logic [CNT_W-1:0]       hcont,
    input  logic [CNT_W-1:0]       vcont,
    input  logic [3*COLOR_W-1:0]   data,
    input  logic                   data_valid,
    input  logic                   underflow_clr,
    output logic                   read_en,
    output logic                   frame_start,
    output logic [COLOR_W-1:0]     R,
    output logic [COLOR_W-1:0]     G,
    output logic [COLOR_W-1:0]     B,
    output logic                   underflow,
    output logic                   busy
);

    localparam int unsigned DATA_W = 3 * COLOR_W;

    // Lookahead position: the pixel whose read request is decided this clock
    logic [CNT_W-1:0] ha;
    logic [CNT_W-1:0] va;
    logic             la_origin;
    logic             la_active;

    vga_lookahead #(
        .CNT_W   (CNT_W),
        .H_TOTAL (H_TOTAL),
        .V_TOTAL (V_TOTAL),
        .OFFSET  (READ_LAT + 1)
    ) u_lookahead (
        .hcont_i (hcont),
        .vcont_i (vcont),
        .ha_o    (ha),
        .va_o    (va)
    );

    assign la_origin = (ha == '0) && (va == '0);
    assign la_active = (ha < CNT_W'(H_ACTIVE)) && (va < CNT_W'(V_ACTIVE));

    fetch_state_t         state_q, state_d;
    logic                 read_en_q, read_en_d;
    logic                 frame_start_q, frame_start_d;
    logic [READ_LAT-1:0]  req_pipe_q, req_pipe_d;
    logic                 pixel_due;
    logic [DATA_W-1:0]    rgb_q, rgb_d;
    logic                 underflow_q, underflow_d;

    // FSM next state; the request uses the next state so the origin pixel of a
    // starting frame is requested and the origin of the following frame is not
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (enable && la_origin)  state_d = ST_FETCH;
            ST_FETCH: if (!enable && la_origin) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
        read_en_d     = (state_d == ST_FETCH) && la_active;
        frame_start_d = read_en_d && la_origin;
    end

    // Request pipeline: one stage per clock of memory latency; the tail marks a due pixel
    if (READ_LAT > 1) begin : g_pipe_multi
        assign req_pipe_d = {req_pipe_q[READ_LAT-2:0], read_en_q};
    end else begin : g_pipe_single
        assign req_pipe_d = read_en_q;
    end

    assign pixel_due = req_pipe_q[READ_LAT-1];

    // Colour select and sticky underflow; a new underflow outranks a clear in the same clock
    always_comb begin
        rgb_d       = '0;
        underflow_d = underflow_q;
        if (underflow_clr) begin
            underflow_d = 1'b0;
        end
        if (pixel_due) begin
            if (data_valid) begin
                rgb_d = data;
            end else begin
                rgb_d       = UNDERFLOW_COLOR;
                underflow_d = 1'b1;
            end
        end
    end

    // State, request and output registers with synchronous reset
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            read_en_q     <= 1'b0;
            frame_start_q <= 1'b0;
            req_pipe_q    <= '0;
            rgb_q         <= '0;
            underflow_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            read_en_q     <= read_en_d;
            frame_start_q <= frame_start_d;
            req_pipe_q    <= req_pipe_d;
            rgb_q         <= rgb_d;
            underflow_q   <= underflow_d;
        end
    end

    assign read_en     = read_en_q;
    assign frame_start = frame_start_q;
    assign R           = rgb_q[3*COLOR_W-1:2*COLOR_W];
    assign G           = rgb_q[2*COLOR_W-1:COLOR_W];
    assign B           = rgb_q[COLOR_W-1:0];
    assign underflow   = underflow_q;
    assign busy        = (state_q == ST_FETCH);

endmodule
